final_layer_controller: RTL

Sequencer for the binarized-network output stage. Loads the ten NUM_INPUTS-bit weight rows of `final_layer_sequential` from a synchronous weight memory once after reset. Accepts one flattened activation vector per image over a valid/ready handshake, clears and enables the final layer, and waits for its done edge under a timeout. Returns the predicted class over a second valid/ready handshake. Sits between the flatten layer and the top-level result interface.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/final_layer_weight_loader.sv | 43 ++++
 rtl/final_layer_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and controller state type for the binarized-network output stage.
package bnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_W     = 4;

  localparam logic [CLASS_W-1:0] TIMEOUT_CLASS = 4'hF;

  typedef enum logic [2:0] {
    ST_LOAD_W  = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_RUN     = 3'd3,
    ST_OUT     = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/final_layer_weight_loader.sv
// Streams the ten final-layer weight rows out of a synchronous memory into a
// register bank while start is held; done marks the cycle of the last capture.
module final_layer_weight_loader
  import bnn_pkg::*;
#(
  parameter int NUM_INPUTS = 196
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   rd_en,
  output logic [CLASS_W-1:0]                     rd_addr,
  input  logic [NUM_INPUTS-1:0]                  rd_data,
  output logic                                   done,
  output logic [NUM_CLASSES-1:0][NUM_INPUTS-1:0] rows
);

  logic [CLASS_W-1:0] cnt;
  logic [CLASS_W-1:0] cap_idx;

  // cnt is both the read address and, one behind, the capture index
  assign rd_en   = start && (cnt < CLASS_W'(NUM_CLASSES));
  assign rd_addr = rd_en ? cnt : '0;
  assign done    = start && (cnt == CLASS_W'(NUM_CLASSES));
  assign cap_idx = cnt - CLASS_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      rows <= '0;
    end else begin
      if (!start || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CLASS_W'(1);
      end
      if (start && (cnt != '0)) begin
        rows[cap_idx] <= rd_data;
      end
    end
  end

endmodule

// File: rtl/final_layer_controller.sv
// Sequencer for the binarized-network output stage: weight load, activation
// handshake, final-layer clear/run with timeout, and result handshake.
module final_layer_controller
  import bnn_pkg::*;
#(
  parameter int NUM_INPUTS     = 196,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_INPUTS-1:0]                  in_data,
  input  logic                                   reload_w,
  output logic                                   wmem_rd_en,
  output logic [CLASS_W-1:0]                     wmem_addr,
  input  logic [NUM_INPUTS-1:0]                  wmem_rd_data,
  output logic                                   fl_reset_n,
  output logic                                   fl_en,
  output logic [NUM_INPUTS-1:0]                  fl_data,
  output logic [NUM_CLASSES-1:0][NUM_INPUTS-1:0] fl_weights,
  input  logic                                   fl_done,
  input  logic [CLASS_W-1:0]                     fl_answer,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CLASS_W-1:0]                     out_class,
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state;
  ctrl_state_t      state_nx;
  logic [CNT_W-1:0] tcnt;
  logic             fl_done_q;
  logic             reload_pend;
  logic             reload_req;
  logic             load_start;
  logic             load_done;
  logic             accept;
  logic             done_edge;
  logic             timed_out;

  // Control outputs are forced to their reset values while reset is held,
  // not only after the first reset edge.
  assign load_start = !reset && (state == ST_LOAD_W);
  assign reload_req = reload_w || reload_pend;
  assign in_ready   = !reset && (state == ST_WAIT_IN) && !reload_req;
  assign accept     = in_valid && in_ready;
  assign fl_en      = !reset && (state == ST_RUN);
  assign fl_reset_n = !reset && (state != ST_CLEAR);
  assign out_valid  = !reset && (state == ST_OUT);
  assign busy       = reset || (state != ST_WAIT_IN);

  assign done_edge = (state == ST_RUN) && fl_done && !fl_done_q;
  assign timed_out = (state == ST_RUN) && !done_edge && (tcnt == T_LAST);

  final_layer_weight_loader #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_loader (
    .clock  (clock),
    .reset  (reset),
    .start  (load_start),
    .rd_en  (wmem_rd_en),
    .rd_addr(wmem_addr),
    .rd_data(wmem_rd_data),
    .done   (load_done),
    .rows   (fl_weights)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD_W:  if (load_done) state_nx = ST_WAIT_IN;
      ST_WAIT_IN: begin
        if (reload_req) begin
          state_nx = ST_LOAD_W;
        end else if (in_valid) begin
          state_nx = ST_CLEAR;
        end
      end
      ST_CLEAR:   state_nx = ST_RUN;
      ST_RUN:     if (done_edge || timed_out) state_nx = ST_OUT;
      ST_OUT:     if (out_ready) state_nx = ST_WAIT_IN;
      default:    state_nx = ST_LOAD_W;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_LOAD_W;
      tcnt        <= '0;
      fl_done_q   <= 1'b0;
      reload_pend <= 1'b0;
      fl_data     <= '0;
      out_class   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_nx;
      fl_done_q <= fl_done;

      // a request arriving outside WAIT_IN is held until it can be served
      if ((state == ST_WAIT_IN) && reload_req) begin
        reload_pend <= 1'b0;
      end else if (reload_w) begin
        reload_pend <= 1'b1;
      end

      if (accept) begin
        fl_data <= in_data;
      end

      if (state == ST_CLEAR) begin
        tcnt <= '0;
      end else if (state == ST_RUN) begin
        tcnt <= tcnt + CNT_W'(1);
      end

      if (done_edge) begin
        out_class <= fl_answer;
      end else if (timed_out) begin
        out_class   <= TIMEOUT_CLASS;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
